// File: rtl/ion_stream_arbiter.sv
// ---------------------------------------------------------------------------
// ion_stream_arbiter : round-robin packet arbiter for up to eight sensor streams
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ion_stream_arbiter #(
    parameter int NUM_STREAMS = 8,
    parameter int DATA_WIDTH  = 110,
    parameter int ID_WIDTH    = 3
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic [NUM_STREAMS-1:0]            sensor_valid,
    input  logic [NUM_STREAMS*DATA_WIDTH-1:0] sensor_data,
    input  logic [NUM_STREAMS-1:0]            stream_enable,
    input  logic                              clear_overflow,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [ID_WIDTH-1:0]               out_stream_id,
    output logic [NUM_STREAMS-1:0]            pending,
    output logic [NUM_STREAMS-1:0]            overflow
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [DATA_WIDTH-1:0]  hold [NUM_STREAMS];
    logic [ID_WIDTH-1:0]    last_grant;
    logic [ID_WIDTH-1:0]    pick;
    logic [ID_WIDTH:0]      cand;
    logic                   found;
    logic                   load;
    logic                   accept;
    logic [NUM_STREAMS-1:0] eligible;
    logic [NUM_STREAMS-1:0] accept_vec;
    logic [NUM_STREAMS-1:0] pending_eff;
    logic [NUM_STREAMS-1:0] capture;
    logic [NUM_STREAMS-1:0] overrun;

    // A slot being drained this cycle counts as free, so a new packet refills it.
    assign eligible    = pending & stream_enable;
    assign pending_eff = pending & ~accept_vec;
    assign capture     = sensor_valid & stream_enable & ~pending_eff;
    assign overrun     = sensor_valid & stream_enable & pending_eff;

    // Walk from farthest to nearest so the closest hit after last_grant wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = NUM_STREAMS; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (ID_WIDTH+1)'(k);
            if (cand >= (ID_WIDTH+1)'(NUM_STREAMS)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_STREAMS);
            end
            if (eligible[cand[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        accept_vec = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    accept                    = 1'b1;
                    accept_vec[out_stream_id] = 1'b1;
                    state_next                = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_stream_id <= '0;
            pending       <= '0;
            overflow      <= '0;
            last_grant    <= ID_WIDTH'(NUM_STREAMS - 1);
        end else begin
            out_valid <= (state_next == SEND);
            pending   <= pending_eff | capture;
            overflow  <= (clear_overflow ? '0 : overflow) | overrun;
            if (load) begin
                out_data      <= hold[pick];
                out_stream_id <= pick;
            end
            if (accept) begin
                last_grant <= out_stream_id;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                hold[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (capture[s]) begin
                    hold[s] <= sensor_data[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ion_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ion_stream_arbiter : directed self-checking bench for ion_stream_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ion_stream_arbiter;

    localparam int NS = 8;
    localparam int DW = 110;
    localparam int IW = 3;

    logic             clock = 1'b0;
    logic             resetn;
    logic [NS-1:0]    sensor_valid;
    logic [NS*DW-1:0] sensor_data;
    logic [NS-1:0]    stream_enable;
    logic             clear_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_stream_id;
    logic [NS-1:0]    pending;
    logic [NS-1:0]    overflow;

    int total = 0;
    int bad   = 0;

    ion_stream_arbiter #(
        .NUM_STREAMS (NS),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IW)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .sensor_valid   (sensor_valid),
        .sensor_data    (sensor_data),
        .stream_enable  (stream_enable),
        .clear_overflow (clear_overflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_stream_id  (out_stream_id),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int s, input logic [DW-1:0] d);
        sensor_data[s*DW +: DW] = d;
        sensor_valid[s]         = 1'b1;
    endtask

    initial begin
        resetn         = 1'b0;
        sensor_valid   = '0;
        sensor_data    = '0;
        stream_enable  = 8'hFF;
        clear_overflow = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", out_stream_id, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        resetn = 1'b1;

        // single packet on stream 2
        out_ready = 1'b1;
        put(2, 110'h3FF_ABCD);
        tick();
        sensor_valid = '0;
        chk("single_pending", pending, 8'h04);
        chk("single_latency", out_valid, 0);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_id", out_stream_id, 2);
        chk("single_data", out_data, 110'h3FF_ABCD);
        tick();
        chk("single_drop_valid", out_valid, 0);
        chk("single_pending_clr", pending, 0);

        // round-robin order from a fresh reset
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        put(5, 110'h55);
        put(1, 110'h11);
        put(6, 110'h66);
        tick();
        sensor_valid = '0;
        tick();
        chk("rr_first_id", out_stream_id, 1);
        chk("rr_first_data", out_data, 110'h11);
        tick();
        chk("rr_gap", out_valid, 0);
        tick();
        chk("rr_second_id", out_stream_id, 5);
        tick();
        tick();
        chk("rr_third_id", out_stream_id, 6);
        chk("rr_third_data", out_data, 110'h66);
        put(0, 110'h1000);
        put(1, 110'h1001);
        tick();
        sensor_valid = '0;
        chk("rr_recap_pending", pending, 8'h03);
        tick();
        chk("rr_wrap_id", out_stream_id, 0);
        chk("rr_wrap_data", out_data, 110'h1000);
        tick();
        tick();
        chk("rr_after_wrap_id", out_stream_id, 1);
        chk("rr_after_wrap_data", out_data, 110'h1001);
        tick();
        chk("rr_done_pending", pending, 0);

        // backpressure on stream 3 with an overrun during the stall
        out_ready = 1'b0;
        put(3, 110'hA3A3);
        tick();
        sensor_valid = '0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) put(3, 110'hBAD);
            else        sensor_valid = '0;
            tick();
            chk("bp_hold", {out_valid, out_stream_id, out_data}, {1'b1, 3'd3, 110'hA3A3});
        end
        sensor_valid = '0;
        chk("bp_overflow", overflow, 8'h08);
        chk("bp_pending", pending, 8'h08);
        out_ready = 1'b1;
        tick();
        chk("bp_accept_valid", out_valid, 0);
        chk("bp_accept_pending", pending, 0);
        chk("bp_overflow_sticky", overflow, 8'h08);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("bp_overflow_clr", overflow, 0);

        // recapture on the accept edge of stream 4
        put(4, 110'hAAAA);
        tick();
        sensor_valid = '0;
        tick();
        chk("recap_a_id", out_stream_id, 4);
        chk("recap_a_data", out_data, 110'hAAAA);
        put(4, 110'hBBBB);
        tick();
        sensor_valid = '0;
        chk("recap_overflow", overflow, 0);
        chk("recap_pending", pending, 8'h10);
        tick();
        chk("recap_b_valid", out_valid, 1);
        chk("recap_b_data", out_data, 110'hBBBB);
        tick();
        chk("recap_done", pending, 0);

        // enable mask
        stream_enable = 8'hFE;
        put(0, 110'hDEAD);
        tick();
        sensor_valid = '0;
        chk("mask_no_capture", pending, 0);
        chk("mask_no_overflow", overflow, 0);
        tick();
        chk("mask_no_grant", out_valid, 0);
        stream_enable = 8'hFF;
        put(7, 110'h7777);
        tick();
        sensor_valid  = '0;
        stream_enable = 8'h7F;
        repeat (4) tick();
        chk("mask_held_no_grant", out_valid, 0);
        chk("mask_held_pending", pending, 8'h80);
        stream_enable = 8'hFF;
        tick();
        chk("mask_reenable_id", out_stream_id, 7);
        chk("mask_reenable_data", out_data, 110'h7777);
        chk("mask_reenable_valid", out_valid, 1);
        tick();
        chk("mask_done", pending, 0);

        // reset while a packet is in flight
        out_ready = 1'b0;
        put(2, 110'h2222);
        put(5, 110'h5555);
        tick();
        sensor_valid = '0;
        tick();
        chk("mid_send_valid", out_valid, 1);
        chk("mid_send_id", out_stream_id, 2);
        put(5, 110'h5A5A);
        tick();
        sensor_valid = '0;
        chk("mid_send_overflow", overflow, 8'h20);
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_id", out_stream_id, 0);
        chk("async_rst_pending", pending, 0);
        chk("async_rst_overflow", overflow, 0);
        resetn = 1'b1;
        tick();
        out_ready = 1'b1;
        put(3, 110'h3333);
        put(0, 110'h0F0F);
        tick();
        sensor_valid = '0;
        tick();
        chk("post_rst_first_id", out_stream_id, 0);
        chk("post_rst_first_data", out_data, 110'h0F0F);
        tick();
        tick();
        chk("post_rst_second_id", out_stream_id, 3);
        tick();
        chk("post_rst_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ion_stream_arbiter.md
# ion_stream_arbiter

Round-robin scheduler that shares one downstream packet channel (toward the Bluetooth transmit path) among up to eight ion-sensor packet streams. Each stream presents a 110-bit packet with a one-cycle valid pulse; the block captures it into a per-stream holding register and grants the channel fairly. The block also holds the packet stable under downstream backpressure and flags packets lost to overrun.

## Interface
- NUM_STREAMS, 8: number of sensor streams, 2..8.
- DATA_WIDTH, 110: packet width in bits.
- ID_WIDTH, 3: width of the stream index, equal to ceil(log2(NUM_STREAMS)).

- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sensor_valid  in  NUM_STREAMS  bit s pulses high for one cycle when stream s presents a packet.
- sensor_data  in  NUM_STREAMS*DATA_WIDTH  stream s packet occupies bits [s*DATA_WIDTH +: DATA_WIDTH]; sampled only when sensor_valid[s]=1.
- stream_enable  in  NUM_STREAMS  bit s=0 makes stream s ineligible for capture and for grant.
- clear_overflow  in  1  one-cycle pulse that clears all overflow bits.
- out_valid  out  1  a packet is presented downstream.
- out_ready  in  1  downstream accepts the packet on a rising edge where out_valid=1 and out_ready=1.
- out_data  out  DATA_WIDTH  granted packet.
- out_stream_id  out  ID_WIDTH  index of the granted stream.
- pending  out  NUM_STREAMS  holding register s is occupied.
- overflow  out  NUM_STREAMS  sticky flag; stream s dropped at least one packet.

## Operation
- **Capture.** When sensor_valid[s]=1, stream_enable[s]=1 and pending[s]=0, store sensor_data slice s and set pending[s].
- **Overrun.** When sensor_valid[s]=1 and pending[s]=1, drop the new packet, keep the held packet and set overflow[s].
- **Accept-cycle exception.** If pending[s] is being cleared by an accept in the same cycle, capture the new packet instead of dropping it. pending[s] stays 1 and overflow is not set.
- **Disabled streams.** sensor_valid[s] with stream_enable[s]=0 is ignored, with no overflow. A packet already held is kept but not granted until the stream is re-enabled.
- **States.** The FSM has two states, IDLE and SEND.
- **IDLE.**
  - Eligible streams are those with pending[s] & stream_enable[s].
  - Search from (last_grant+1) mod NUM_STREAMS upward, with wrap-around.
  - On the first hit g: load out_data from holding register g, set out_stream_id=g, go to SEND.
  - With no eligible stream, remain in IDLE.
- **SEND.**
  - out_valid=1. out_data and out_stream_id hold constant, regardless of stream_enable changes.
  - On accept: clear pending[g], set last_grant=g, go to IDLE.
  - out_valid never drops without an accept.
- **Overflow clear.** clear_overflow clears all overflow bits. A new overrun in the same cycle wins, so that bit stays 1.
- **Reset.** Asserting resetn low at any time, including mid-SEND, immediately clears all state. The in-flight packet is discarded.

## Timing
- **Reset values:**
  - out_valid=0, out_data=0, out_stream_id=0
  - pending=0, overflow=0
  - state IDLE, last_grant=NUM_STREAMS-1, so stream 0 has first priority.
- **Latency.** sensor_valid[s] sampled at edge k gives pending[s]=1 after edge k. With the FSM idle and s the only eligible stream, the transition to SEND occurs at edge k+1. out_valid is high from edge k+1 to edge k+2, the first possible accept.
- **Throughput.** At most one packet per two cycles: one SEND cycle plus one IDLE cycle between grants.
- **Registered outputs.** All outputs are registered. No combinational path runs from out_ready to out_valid or out_data.
- **Fairness.** With all streams continuously eligible, the grant order is 0,1,...,NUM_STREAMS-1,0,...

## Test plan
- **Single packet.** Stream 2 pulses valid with data 110'h3FF_ABCD at edge 0, out_ready=1 -> out_valid high for exactly one cycle after edge 1, out_stream_id=2, out_data=110'h3FF_ABCD, pending=0 after the accept.
- **Round-robin order.** Streams 5, 1 and 6 pulse valid in the same cycle after reset -> grants in order 1, 5, 6. Then stream 1 pulses again while stream 0 also pulses -> next grant is stream 0, then stream 1 (wrap-around from last_grant=6).
- **Backpressure.** Stream 3 is granted and out_ready is held 0 for 20 cycles -> out_valid, out_data and out_stream_id are constant for 20 cycles. A second stream 3 pulse during the stall sets overflow[3]=1 and the original data is delivered. clear_overflow then returns overflow to 0.
- **Same-cycle recapture.** Stream 4 pulses valid with data B on the accept edge of its data-A packet -> no overflow, pending[4] stays 1, and the next grant of stream 4 delivers B.
- **Enable mask.** stream_enable=8'hFE while stream 0 pulses -> no capture, no overflow. Stream 7 is held pending, then disabled before its grant -> never granted until re-enabled, then delivered.
- **Reset mid-SEND.** resetn is pulsed low while out_valid=1 with other streams pending -> all outputs at reset values immediately. The next grant after reset follows stream-0-first priority.
